// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage
// Returns the remainder on hi_out and the quotient on lo_out, and stalls IF..EX while a divide runs.
// Ports:
//   clk, resetn              clock (rising edge), asynchronous active-low reset
//   alucontrol[7:0]          EX op code; EXE_DIV_OP / EXE_DIVU_OP start a divide
//   srca, srcb [WIDTH-1:0]   dividend (rs), divisor (rt); sampled only when a divide starts
//   flush                    annuls the EX instruction; aborts a running divide
//   div_stall                hold IF..EX (combinational)
//   div_valid                1-cycle pulse: hi_out/lo_out hold a new result
//   hi_out, lo_out           remainder, quotient; held between completions
// Optional feature macro: DIV_ZERO_FAST_EN
//   When it is defined, a zero divisor skips the iterations and goes straight to DONE.
`ifndef EXE_DIV_OP
`define EXE_DIV_OP 8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             div_stall,
  output logic             div_valid,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_quo, r_den;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r;
  logic             w_is_div, w_start, w_last, w_zero_fast;
  logic [WIDTH:0]   w_trial, w_diff;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
  assign w_is_div = alucontrol == `EXE_DIV_OP;
  assign w_start  = (w_is_div || alucontrol == `EXE_DIVU_OP) && !flush;
  assign w_last   = r_cnt == CW'(WIDTH - 1);
`ifdef DIV_ZERO_FAST_EN
  assign w_zero_fast = srcb == '0;
`else
  assign w_zero_fast = 1'b0;
`endif
  // Shift the next dividend bit into the partial remainder; a non-negative trial difference
  // means the divisor fits, so keep the difference and emit a 1 quotient bit.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_trial - {1'b0, r_den};
  assign w_rem_nxt = w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? (w_zero_fast ? DONE : BUSY) : IDLE;
      BUSY:    w_next = flush ? IDLE : (w_last ? DONE : BUSY);
      default: w_next = IDLE;
    endcase
  end
  assign div_stall = resetn && ((r_state == IDLE && w_start) || r_state == BUSY);
  // A flush in DONE annuls the divide, so its completion pulse is suppressed too.
  assign div_valid = r_state == DONE && !flush;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_den   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else if (r_state == IDLE && w_start) begin
      // Magnitudes only for DIV; the signs are reapplied when the result is written.
      r_quo   <= (w_is_div && srca[WIDTH-1]) ? -srca : srca;
      r_den   <= (w_is_div && srcb[WIDTH-1]) ? -srcb : srcb;
      r_neg_q <= w_is_div && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      r_neg_r <= w_is_div && srca[WIDTH-1];
      r_rem   <= '0;
      r_cnt   <= '0;
      // Fast zero-divisor path reproduces what the full iteration would produce.
      if (w_zero_fast) begin
        hi_out <= srca;
        lo_out <= (w_is_div && srca[WIDTH-1]) ? WIDTH'(1) : '1;
      end
    end else if (r_state == BUSY && !flush) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        hi_out <= r_neg_r ? -w_rem_nxt : w_rem_nxt;
        lo_out <= r_neg_q ? -w_quo_nxt : w_quo_nxt;
      end
    end
  end
endmodule
